// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like responder: access-size encoding,
// default sizing and the byte write-enable decode.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  localparam int unsigned DEPTH_DEFAULT     = 4;
  localparam logic [7:0]  LFSR_SEED_DEFAULT = 8'hA5;

  // Unaligned half/word accesses fall onto the aligned-down lanes.
  function automatic logic [3:0] wen_decode(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] wen;
    case (size_e'(size))
      SIZE_BYTE: wen = 4'b0001 << lane;
      SIZE_HALF: wen = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: wen = '1;
      default:   wen = '0;
    endcase
    return wen;
  endfunction

endpackage

// File: rtl/sram_like2sram_resp_fifo.sv
// resp_fifo: synchronous FIFO holding completed responses until delivered.
// DEPTH must be a power of two so the pointers wrap naturally.
module resp_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;

  assign do_pop = pop && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/sram_like2sram.sv
// sram-like responder in front of a 1-cycle synchronous SRAM; responses in order.
// Optional random accept stalls when SRAM_LIKE_DELAY_EN is defined.
module sram_like2sram
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter logic [7:0]  LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          pipe_valid;
  logic          pipe_zero;
  logic [31:0]   pipe_data;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_rdata;
  logic [CW-1:0] outstanding;
  logic          has_room;
  logic          gate_ok;

`ifdef SRAM_LIKE_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign gate_ok = (lfsr[1:0] == 2'b00);
`else
  assign gate_ok = 1'b1;
`endif

  // A pop in the same cycle is deliberately not credited back to capacity.
  assign outstanding = fifo_count + CW'(pipe_valid);
  assign has_room    = (outstanding < CW'(DEPTH));
  assign addr_ok     = resetn && req && has_room && gate_ok;

  assign ram_en    = addr_ok;
  assign ram_wen   = (addr_ok && wr) ? wen_decode(size, addr[1:0]) : '0;
  assign ram_addr  = {addr[31:2], 2'b00};
  assign ram_wdata = wdata;

  // Writes and illegal-size accesses both answer with zero data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pipe_valid <= 1'b0;
      pipe_zero  <= 1'b0;
    end else begin
      pipe_valid <= addr_ok;
      pipe_zero  <= wr || (size == SIZE_ILL);
    end
  end

  assign pipe_data = pipe_zero ? '0 : ram_rdata;
  assign fifo_push = pipe_valid && !fifo_full;

  resp_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .wdata  (pipe_data),
    .pop    (data_ok),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign data_ok = resetn && !fifo_empty;
  assign rdata   = data_ok ? fifo_rdata : '0;

endmodule
